// File: rtl/icache_pkg.sv
// icache_pkg: state encoding, clog2 helper and default address-field widths
// shared by icache_dm and icache_tag_ram.
package icache_pkg;

    localparam logic [1:0] IDLE    = 2'd0;
    localparam logic [1:0] REFILL  = 2'd1;
    localparam logic [1:0] RESPOND = 2'd2;

    localparam int DEF_LINES      = 64;
    localparam int DEF_LINE_WORDS = 4;

    function automatic int clog2(input int value);
        int r;
        r = 0;
        for (int i = 0; i < 31; i++) begin
            if ((1 << i) < value) r = i + 1;
        end
        return r;
    endfunction

    localparam int OFF_W = clog2(DEF_LINE_WORDS);
    localparam int IDX_W = clog2(DEF_LINES);
    localparam int TAG_W = 30 - OFF_W - IDX_W;

endpackage

// File: rtl/icache_tag_ram.sv
// icache_tag_ram: per-line valid bit and tag store with combinational hit lookup.
// Valid bits clear synchronously on rst (active-low); tags need no reset.
module icache_tag_ram
    import icache_pkg::*;
#(
    parameter int LINES    = DEF_LINES,
    parameter int TAG_BITS = TAG_W,
    parameter int IDX_BITS = clog2(LINES)
) (
    input  logic                clk,
    input  logic                rst,
    input  logic [IDX_BITS-1:0] rd_idx,
    input  logic [TAG_BITS-1:0] rd_tag,
    output logic                hit,
    input  logic                wr_en,
    input  logic [IDX_BITS-1:0] wr_idx,
    input  logic [TAG_BITS-1:0] wr_tag,
    input  logic                wr_valid
);

    logic [LINES-1:0]    valid_bits;
    logic [TAG_BITS-1:0] tags [LINES];

    assign hit = valid_bits[rd_idx] && (tags[rd_idx] == rd_tag);

    always_ff @(posedge clk) begin
        if (!rst) begin
            valid_bits <= '0;
        end else if (wr_en) begin
            valid_bits[wr_idx] <= wr_valid;
        end
    end

    always_ff @(posedge clk) begin
        if (rst && wr_en) begin
            tags[wr_idx] <= wr_tag;
        end
    end

endmodule

// File: rtl/icache_dm.sv
// icache_dm: direct-mapped, blocking, read-only instruction cache with one-line burst refill.
// Define ICACHE_PERF_EN to add saturating perf_hits / perf_misses counters.
module icache_dm
    import icache_pkg::*;
#(
    parameter int          LINES      = DEF_LINES,
    parameter int          LINE_WORDS = DEF_LINE_WORDS,
    parameter logic [31:0] RESET_PC   = 32'h0040_0000
) (
    input  logic        clk,
    input  logic        rst,
    input  logic        icache_ena,
    input  logic [31:0] icache_addr,
    output logic        icache_valid,
    output logic [31:0] icache_data,
    output logic        mem_req,
    output logic [31:0] mem_addr,
    input  logic        mem_rvalid,
    input  logic [31:0] mem_rdata,
    input  logic        mem_rlast
`ifdef ICACHE_PERF_EN
    ,
    output logic [31:0] perf_hits,
    output logic [31:0] perf_misses
`endif
);

    // state   | meaning
    // IDLE    | accept requests; hits answered next cycle
    // REFILL  | collecting burst beats into the latched line
    // RESPOND | present the latched word, then back to IDLE

    localparam int OFF_BITS = clog2(LINE_WORDS);
    localparam int IDX_BITS = clog2(LINES);
    localparam int TAG_BITS = 30 - OFF_BITS - IDX_BITS;
    localparam int LINE_LSB = OFF_BITS + 2;
    localparam int TAG_LSB  = LINE_LSB + IDX_BITS;
    localparam logic [OFF_BITS-1:0] LAST_BEAT = OFF_BITS'(LINE_WORDS - 1);

    logic [1:0]          state;
    logic [OFF_BITS-1:0] req_off;
    logic [OFF_BITS-1:0] lat_off;
    logic [OFF_BITS-1:0] beat_cnt;
    logic [IDX_BITS-1:0] req_idx;
    logic [IDX_BITS-1:0] lat_idx;
    logic [TAG_BITS-1:0] req_tag;
    logic [TAG_BITS-1:0] lat_tag;
    logic                hit;
    logic                accept;
    logic                refill_beat;
    logic                refill_done;
    logic                line_good;
    logic                unused_bits;

    logic [31:0] data_mem [LINES*LINE_WORDS];

    assign req_off     = icache_addr[LINE_LSB-1:2];
    assign req_idx     = icache_addr[TAG_LSB-1:LINE_LSB];
    assign req_tag     = icache_addr[31:TAG_LSB];
    assign unused_bits = ^icache_addr[1:0];

    assign accept      = (state == IDLE) && icache_ena;
    assign refill_beat = (state == REFILL) && mem_rvalid;
    assign refill_done = refill_beat && mem_rlast;
    // An rlast that does not land on the final word leaves the line invalid.
    assign line_good   = (beat_cnt == LAST_BEAT);

    icache_tag_ram #(
        .LINES    (LINES),
        .TAG_BITS (TAG_BITS),
        .IDX_BITS (IDX_BITS)
    ) u_tag_ram (
        .clk      (clk),
        .rst      (rst),
        .rd_idx   (req_idx),
        .rd_tag   (req_tag),
        .hit      (hit),
        .wr_en    (refill_done),
        .wr_idx   (lat_idx),
        .wr_tag   (lat_tag),
        .wr_valid (line_good)
    );

    always_ff @(posedge clk) begin
        if (rst && refill_beat) begin
            data_mem[{lat_idx, beat_cnt}] <= mem_rdata;
        end
    end

    always_ff @(posedge clk) begin
        if (!rst) begin
            state        <= IDLE;
            icache_valid <= 1'b0;
            icache_data  <= 32'd0;
            mem_req      <= 1'b0;
            mem_addr     <= 32'd0;
            beat_cnt     <= '0;
            lat_tag      <= RESET_PC[31:TAG_LSB];
            lat_idx      <= RESET_PC[TAG_LSB-1:LINE_LSB];
            lat_off      <= RESET_PC[LINE_LSB-1:2];
        end else begin
            case (state)
                IDLE: begin
                    if (accept) begin
                        if (hit) begin
                            icache_data  <= data_mem[{req_idx, req_off}];
                            icache_valid <= 1'b1;
                        end else begin
                            lat_tag      <= req_tag;
                            lat_idx      <= req_idx;
                            lat_off      <= req_off;
                            icache_valid <= 1'b0;
                            mem_req      <= 1'b1;
                            mem_addr     <= {icache_addr[31:LINE_LSB], {LINE_LSB{1'b0}}};
                            beat_cnt     <= '0;
                            state        <= REFILL;
                        end
                    end
                end
                REFILL: begin
                    if (refill_beat) begin
                        beat_cnt <= beat_cnt + OFF_BITS'(1);
                        if (mem_rlast) begin
                            mem_req <= 1'b0;
                            state   <= RESPOND;
                        end
                    end
                end
                RESPOND: begin
                    icache_data  <= data_mem[{lat_idx, lat_off}];
                    icache_valid <= 1'b1;
                    beat_cnt     <= '0;
                    state        <= IDLE;
                end
                default: begin
                    state <= IDLE;
                end
            endcase
        end
    end

`ifdef ICACHE_PERF_EN
    always_ff @(posedge clk) begin
        if (!rst) begin
            perf_hits   <= 32'd0;
            perf_misses <= 32'd0;
        end else if (accept) begin
            if (hit) begin
                if (perf_hits != 32'hFFFF_FFFF) perf_hits <= perf_hits + 32'd1;
            end else begin
                if (perf_misses != 32'hFFFF_FFFF) perf_misses <= perf_misses + 32'd1;
            end
        end
    end
`endif

endmodule
